// File: rtl/sap_pkg.sv
// Shared SAP definitions: default bus/address widths and the programming FSM states.
package sap_pkg;

  localparam int SAP_DATA_W = 8;
  localparam int SAP_ADDR_W = 4;

  typedef enum logic [1:0] {
    P_IDLE    = 2'd0,
    P_WRITE   = 2'd1,
    P_RELEASE = 2'd2
  } prog_state_e;

endpackage

// File: rtl/sap_debounce.sv
// Two-flop synchroniser plus stable-sample debouncer for the raw program button.
module sap_debounce #(
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic clk,
  input  logic clr,
  input  logic btn_raw,
  output logic btn_db,
  output logic btn_rise
);

  localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             db_q, db_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The counter only advances while the synchronised input disagrees with the
  // debounced output; any agreeing sample restarts the stability window.
  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    db_d    = db_q;
    cnt_d   = '0;
    if (sync2_q != db_q) begin
      if (cnt_q == CNT_LAST) begin
        db_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      db_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
    end
  end

  // Rise strobe is taken from the next-state value so the FSM reacts on the
  // same edge the debounced level goes high.
  assign btn_db   = db_q;
  assign btn_rise = db_d & ~db_q;

endmodule

// File: rtl/sap_ram_prog.sv
// SAP program RAM with run-mode bus access and debounced DIP-switch programming.
// Define SAP_RAM_AUTOINC_EN to take the program address from an auto-incrementing pointer.
module sap_ram_prog
  import sap_pkg::*;
#(
  parameter int DATA_W       = SAP_DATA_W,
  parameter int ADDR_W       = SAP_ADDR_W,
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              prog_mode,
  input  logic [ADDR_W-1:0] dip_addr,
  input  logic [DATA_W-1:0] dip_data,
  input  logic              prog_btn,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              mar_load,
  input  logic              ram_in,
  input  logic              ram_out,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_oe,
  output logic [ADDR_W-1:0] mar_q,
  output logic [DATA_W-1:0] disp_data,
  output logic              prog_busy
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] mar_d;
  prog_state_e       state_q, state_d;
  logic              btn_db, btn_rise;
  logic              prog_wr, run_wr, wr_en;
  logic [ADDR_W-1:0] prog_addr, active_addr, wr_addr;
  logic [DATA_W-1:0] wr_data;

  sap_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_debounce (
    .clk      (clk),
    .clr      (clr),
    .btn_raw  (prog_btn),
    .btn_db   (btn_db),
    .btn_rise (btn_rise)
  );

`ifdef SAP_RAM_AUTOINC_EN
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              mode_q, mode_d;

  always_comb begin
    mode_d = prog_mode;
    ptr_d  = ptr_q;
    if (prog_mode && !mode_q) begin
      ptr_d = dip_addr;
    end else if (prog_wr) begin
      ptr_d = ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      ptr_q  <= '0;
      mode_q <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      mode_q <= mode_d;
    end
  end

  assign prog_addr = ptr_q;
`else
  assign prog_addr = dip_addr;
`endif

  // Leaving program mode forces the FSM idle, which also cancels a pending write.
  always_comb begin
    state_d = state_q;
    if (!prog_mode) begin
      state_d = P_IDLE;
    end else begin
      case (state_q)
        P_IDLE:    if (btn_rise) state_d = P_WRITE;
        P_WRITE:   state_d = P_RELEASE;
        P_RELEASE: if (!btn_db) state_d = P_IDLE;
        default:   state_d = P_IDLE;
      endcase
    end
  end

  always_comb begin
    prog_wr     = (state_q == P_WRITE) && prog_mode;
    run_wr      = !prog_mode && ram_in;
    wr_en       = (prog_wr || run_wr) && !clr;
    wr_addr     = prog_mode ? prog_addr : mar_q;
    wr_data     = prog_mode ? dip_data : bus_in;
    active_addr = prog_mode ? prog_addr : mar_q;
    mar_d       = mar_q;
    if (!prog_mode && mar_load) begin
      mar_d = bus_in[ADDR_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      mar_q   <= '0;
      state_q <= P_IDLE;
    end else begin
      mar_q   <= mar_d;
      state_q <= state_d;
    end
  end

  // Memory has no reset; contents survive clr.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign bus_oe    = ram_out && !prog_mode;
  assign bus_out   = bus_oe ? mem_q[mar_q] : '0;
  assign disp_data = mem_q[active_addr];
  assign prog_busy = (state_q != P_IDLE);

endmodule

// File: tb/tb_sap_ram_prog.sv
// Directed bench for sap_ram_prog: run-mode vector table plus program-mode sequences.
module tb_sap_ram_prog;

  localparam int DW = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          clr = 1'b0;
  logic          prog_mode = 1'b0;
  logic [AW-1:0] dip_addr = '0;
  logic [DW-1:0] dip_data = '0;
  logic          prog_btn = 1'b0;
  logic [DW-1:0] bus_in = '0;
  logic          mar_load = 1'b0;
  logic          ram_in = 1'b0;
  logic          ram_out = 1'b0;
  logic [DW-1:0] bus_out;
  logic          bus_oe;
  logic [AW-1:0] mar_q;
  logic [DW-1:0] disp_data;
  logic          prog_busy;

  int checks = 0;
  int errors = 0;

  sap_ram_prog #(.DATA_W(DW), .ADDR_W(AW), .DEBOUNCE_CYC(4)) dut (
    .clk       (clk),
    .clr       (clr),
    .prog_mode (prog_mode),
    .dip_addr  (dip_addr),
    .dip_data  (dip_data),
    .prog_btn  (prog_btn),
    .bus_in    (bus_in),
    .mar_load  (mar_load),
    .ram_in    (ram_in),
    .ram_out   (ram_out),
    .bus_out   (bus_out),
    .bus_oe    (bus_oe),
    .mar_q     (mar_q),
    .disp_data (disp_data),
    .prog_busy (prog_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          mode;
    logic          ld;
    logic          wr;
    logic          oe;
    logic [DW-1:0] bus;
    logic [DW-1:0] pre_out;
    logic [AW-1:0] exp_mar;
    logic          exp_oe;
    logic [DW-1:0] exp_out;
    logic [DW-1:0] exp_disp;
  } vec_t;

  vec_t vecs [9];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic read_mem(input logic [AW-1:0] a, output logic [DW-1:0] d);
    prog_mode = 1'b0;
    bus_in    = {{(DW-AW){1'b0}}, a};
    mar_load  = 1'b1;
    tick(1);
    mar_load  = 1'b0;
    #1;
    d = disp_data;
  endtask

  task automatic apply_stimulus(input vec_t v);
    prog_mode = v.mode;
    mar_load  = v.ld;
    ram_in    = v.wr;
    ram_out   = v.oe;
    bus_in    = v.bus;
    #1;
    check_output("bus_out_pre_edge", bus_out, v.pre_out);
    tick(1);
    mar_load = 1'b0;
    ram_in   = 1'b0;
    #1;
  endtask

  initial begin
    logic [DW-1:0] rd;
    logic          seen_busy;
    logic [DW-1:0] auto_data [3];

    vecs[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'hF7, 8'h00, 4'h7, 1'b0, 8'h00, 8'hC7};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 8'hC7, 4'h7, 1'b1, 8'hA5, 8'hA5};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 4'h7, 1'b0, 8'h00, 8'hA5};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h02, 8'h00, 4'h2, 1'b0, 8'h00, 8'hC2};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h05, 8'hC2, 4'h5, 1'b1, 8'hC5, 8'hC5};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h02, 8'hC5, 4'h2, 1'b1, 8'h05, 8'h05};
    vecs[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h0A, 8'h00, 4'h2, 1'b0, 8'h00, 8'h05};
    vecs[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h13, 8'h00, 4'h3, 1'b0, 8'h00, 8'hC3};
    vecs[8] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h5A, 8'hC3, 4'h3, 1'b1, 8'h5A, 8'h5A};

    // Reset state
    clr = 1'b1;
    tick(2);
    clr = 1'b0;
    #1;
    check_output("reset_mar", mar_q, 4'h0);
    check_output("reset_bus_oe", bus_oe, 1'b0);
    check_output("reset_bus_out", bus_out, 8'h00);
    check_output("reset_busy", prog_busy, 1'b0);

    // Preload every location with 0xC0 | addr
    for (int a = 0; a < 16; a++) begin
      bus_in   = 8'(a);
      mar_load = 1'b1;
      tick(1);
      mar_load = 1'b0;
      bus_in   = 8'hC0 | 8'(a);
      ram_in   = 1'b1;
      tick(1);
      ram_in   = 1'b0;
    end

    // Run-mode vector table
    dip_addr = 4'h2;
    dip_data = 8'hDD;
    for (int i = 0; i < 9; i++) begin
      apply_stimulus(vecs[i]);
      check_output($sformatf("vec%0d_mar", i), mar_q, vecs[i].exp_mar);
      check_output($sformatf("vec%0d_bus_oe", i), bus_oe, vecs[i].exp_oe);
      check_output($sformatf("vec%0d_bus_out", i), bus_out, vecs[i].exp_out);
      check_output($sformatf("vec%0d_disp", i), disp_data, vecs[i].exp_disp);
    end
    ram_out = 1'b0;

    // clr with a write strobe: MAR cleared, memory untouched
    clr    = 1'b1;
    ram_in = 1'b1;
    bus_in = 8'hEE;
    tick(1);
    clr    = 1'b0;
    ram_in = 1'b0;
    #1;
    check_output("clr_mar", mar_q, 4'h0);
    check_output("clr_bus_oe", bus_oe, 1'b0);
    check_output("clr_bus_out", bus_out, 8'h00);
    check_output("clr_busy", prog_busy, 1'b0);
    read_mem(4'h3, rd);
    check_output("clr_keeps_mem3", rd, 8'h5A);

    // Program write, button held 20 cycles: write lands on edge 7
    dip_addr  = 4'h9;
    dip_data  = 8'h3C;
    prog_mode = 1'b1;
    tick(2);
    prog_btn = 1'b1;
    tick(5);
    check_output("prog_busy_edge5", prog_busy, 1'b0);
    tick(1);
    check_output("prog_busy_edge6", prog_busy, 1'b1);
    check_output("prog_disp_before_write", disp_data, 8'hC9);
    tick(1);
    check_output("prog_busy_edge7", prog_busy, 1'b1);
`ifdef SAP_RAM_AUTOINC_EN
    check_output("prog_disp_after_write", disp_data, 8'hCA);
`else
    check_output("prog_disp_after_write", disp_data, 8'h3C);
`endif
    dip_data = 8'h77;
    tick(13);
    check_output("prog_busy_while_held", prog_busy, 1'b1);
    prog_btn = 1'b0;
    tick(6);
    check_output("release_busy_edge6", prog_busy, 1'b1);
    tick(1);
    check_output("release_busy_edge7", prog_busy, 1'b0);
    read_mem(4'h9, rd);
    check_output("prog_single_write_mem9", rd, 8'h3C);

    // Bounce rejection
    dip_addr  = 4'h4;
    dip_data  = 8'h99;
    prog_mode = 1'b1;
    tick(2);
    seen_busy = 1'b0;
    for (int i = 0; i < 10; i++) begin
      prog_btn = ((i >> 1) & 1) == 0;
      tick(1);
      if (prog_busy) seen_busy = 1'b1;
    end
    prog_btn = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (prog_busy) seen_busy = 1'b1;
    end
    check_output("bounce_busy_seen", seen_busy, 1'b0);
    read_mem(4'h4, rd);
    check_output("bounce_mem4", rd, 8'hC4);

    // prog_mode dropped during debounce
    dip_addr  = 4'h6;
    dip_data  = 8'h66;
    prog_mode = 1'b1;
    tick(2);
    prog_btn = 1'b1;
    tick(3);
    prog_mode = 1'b0;
    tick(10);
    prog_btn = 1'b0;
    tick(10);
    check_output("abort_debounce_busy", prog_busy, 1'b0);
    read_mem(4'h6, rd);
    check_output("abort_debounce_mem6", rd, 8'hC6);

    // prog_mode dropped while P_WRITE is pending
    dip_addr  = 4'h8;
    dip_data  = 8'h88;
    prog_mode = 1'b1;
    tick(2);
    prog_btn = 1'b1;
    tick(6);
    check_output("pending_busy", prog_busy, 1'b1);
    prog_mode = 1'b0;
    tick(1);
    check_output("pending_abort_busy", prog_busy, 1'b0);
    prog_btn = 1'b0;
    tick(10);
    read_mem(4'h8, rd);
    check_output("pending_abort_mem8", rd, 8'hC8);

    // Three presses from dip_addr 0xE
    auto_data[0] = 8'h11;
    auto_data[1] = 8'h22;
    auto_data[2] = 8'h33;
    prog_mode = 1'b0;
    dip_addr  = 4'hE;
    tick(1);
    prog_mode = 1'b1;
    tick(2);
    for (int p = 0; p < 3; p++) begin
      dip_data = auto_data[p];
      prog_btn = 1'b1;
      tick(10);
      prog_btn = 1'b0;
      tick(10);
      check_output($sformatf("press%0d_idle", p), prog_busy, 1'b0);
    end
    read_mem(4'hE, rd);
`ifdef SAP_RAM_AUTOINC_EN
    check_output("auto_memE", rd, 8'h11);
    read_mem(4'hF, rd);
    check_output("auto_memF", rd, 8'h22);
    read_mem(4'h0, rd);
    check_output("auto_mem0_wrap", rd, 8'h33);
`else
    check_output("fixed_memE", rd, 8'h33);
    read_mem(4'hF, rd);
    check_output("fixed_memF", rd, 8'hCF);
    read_mem(4'h0, rd);
    check_output("fixed_mem0", rd, 8'hC0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sap_ram_prog.md
Name: sap_ram_prog

Overview:
- Parametrised successor to the SAP program RAM: DATA_W x 2^ADDR_W memory with an internal memory address register (MAR) and two operating modes.
- Run mode: the MAR and the memory are loaded from the shared bus under control-word strobes.
- Program mode: the operator writes words from DIP switches using a debounced, edge-triggered write button driving a small FSM. Writes are never level-sensitive on the raw switch.
- Sits on the 8-bit SAP bus beside the A/B registers and the controller.

Parameters:
- DATA_W, 8, memory word width and bus width.
- ADDR_W, 4, address width; depth = 2^ADDR_W.
- DEBOUNCE_CYC, 4, consecutive stable samples required before the button changes state; minimum 1.

Ports:
- clk  in  1  system clock, all state on rising edge
- clr  in  1  synchronous active-high reset
- prog_mode  in  1  1 = program mode, 0 = run mode
- dip_addr  in  ADDR_W  program-mode address switches
- dip_data  in  DATA_W  program-mode data switches
- prog_btn  in  1  raw asynchronous write button, active-high
- bus_in  in  DATA_W  shared bus value
- mar_load  in  1  run mode: load MAR from bus_in[ADDR_W-1:0]
- ram_in  in  1  run mode: write bus_in to mem[MAR]
- ram_out  in  1  run mode: drive mem[MAR] onto bus
- bus_out  out  DATA_W  mem[MAR] when bus_oe, else 0
- bus_oe  out  1  high when ram_out && !prog_mode
- mar_q  out  ADDR_W  current MAR, for LEDs
- disp_data  out  DATA_W  mem[active address], for LEDs
- prog_busy  out  1  programming FSM not in P_IDLE

Behaviour:
- Reset (clr=1 at rising edge):
  - MAR=0; FSM=P_IDLE; synchroniser and debounce state cleared; debounced button=0.
  - Memory contents are NOT cleared.
  - Outputs after reset: bus_oe=0, bus_out=0, prog_busy=0.
- Active address:
  - Run mode: MAR.
  - Program mode: dip_addr (or the auto-increment pointer, see Optional Feature).
- Reads are asynchronous (combinational from the array): disp_data = mem[active address] continuously.
- Run mode, all actions at the rising edge:
  - mar_load: MAR <= bus_in[ADDR_W-1:0]; upper bits ignored.
  - ram_in: mem[MAR] <= bus_in.
  - mar_load and ram_in together: the write uses the old MAR, then MAR updates.
  - ram_in and ram_out together: bus_out shows old data until the edge, new data after it.
  - prog_btn is ignored and the FSM is held in P_IDLE.
- Program mode:
  - mar_load, ram_in and ram_out are ignored; bus_oe=0.
  - MAR holds its value.
- Button path:
  - 2-flop synchroniser, then debouncer: the output changes only after DEBOUNCE_CYC consecutive equal samples.
- FSM:
  - P_IDLE -> P_WRITE on a debounced rising edge while prog_mode=1.
  - P_WRITE (exactly 1 cycle): mem[dip_addr] <= dip_data; -> P_RELEASE.
  - P_RELEASE -> P_IDLE once the debounced button = 0.
  - Holding the button produces exactly one write.
- prog_mode falling while the FSM is busy: FSM -> P_IDLE next cycle; a pending P_WRITE is not performed if prog_mode is already 0 in that cycle.
- clr mid-operation overrides everything; no write occurs in the reset cycle.
- Latency: raw button rise -> memory write = 2 (sync) + DEBOUNCE_CYC + 1 cycles.

Optional Feature:
- Macro: SAP_RAM_AUTOINC_EN.
- Enabled:
  - An internal ADDR_W pointer supplies the program-mode address.
  - The pointer loads dip_addr on each 0->1 transition of prog_mode.
  - It increments after every P_WRITE, wrapping 2^ADDR_W-1 -> 0.
  - Reset value 0.
  - disp_data follows the pointer.
- Disabled: the program-mode address is dip_addr directly; there is no pointer.

Decomposition:
- Package sap_pkg holds:
  - the FSM state enum (P_IDLE, P_WRITE, P_RELEASE);
  - default DATA_W/ADDR_W constants shared with the bus and registers.
- One sub-module: sap_debounce, containing the synchroniser, the stable-count counter and the debounced output, parametrised by DEBOUNCE_CYC.

Test Plan:
- Reset: write 0x5A to addr 3 in run mode, pulse clr -> mar_q=0, bus_oe=0, prog_busy=0, and mem[3] still reads 0x5A after MAR is reloaded with 3.
- Run write/read: mar_load with bus_in=0xF7 -> mar_q=0x7; ram_in with bus_in=0xA5 -> with ram_out=1, bus_out=0xA5 and bus_oe=1; with ram_out=0, bus_out=0.
- Program write with DEBOUNCE_CYC=4: prog_mode=1, dip_addr=0x9, dip_data=0x3C, hold prog_btn for 20 cycles -> exactly one write at cycle 7 after the rise; mem[9]=0x3C; prog_busy returns to 0 after release.
- Bounce rejection: prog_btn toggles every 2 cycles for 10 cycles, then stays low -> no write, FSM stays in P_IDLE.
- Mode abort and simultaneous strobes:
  - Drop prog_mode during debounce -> no write.
  - Run mode, mar_load and ram_in together with MAR=2 and bus_in=0x05 -> mem[2]=0x05, mar_q=5.
- With SAP_RAM_AUTOINC_EN, dip_addr=0xE: three button presses writing 0x11, 0x22, 0x33 -> mem[E]=0x11, mem[F]=0x22, mem[0]=0x33 (wrap).
